// File: rtl/receive_ascii_as_binary.sv
// ASCII '0'/'1' digit receiver: pops characters from the uart_rx6 FIFO,
// assembles WIDTH digits (MSB first) into a word offered on valid/ready,
// and pulses frame_error on illegal characters or truncated words.
module receive_ascii_as_binary #(
  parameter int WIDTH    = 8,
  parameter int ALLOW_WS = 1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_data_present,
  output logic                         rx_read,
  output logic [WIDTH-1:0]             binary_out,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic                         frame_error,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

  localparam int BCW = $clog2(WIDTH+1);

  typedef enum logic {FETCH, SETTLE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       char_q, char_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [WIDTH-1:0] bout_q, bout_d;
  logic             wv_q, wv_d;
  logic             fe_q, fe_d;
  logic             rd_q, rd_d;

  logic is_digit, is_space, is_eol;

  // Character classes; whitespace classes collapse to "illegal" when disabled.
  always_comb begin
    is_digit = (char_q == 8'h30) || (char_q == 8'h31);
    is_space = (ALLOW_WS != 0) && ((char_q == 8'h20) || (char_q == 8'h09));
    is_eol   = (ALLOW_WS != 0) && ((char_q == 8'h0D) || (char_q == 8'h0A));
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    bout_d  = bout_q;
    wv_d    = wv_q;
    fe_d    = 1'b0;
    rd_d    = 1'b0;

    // Acceptance only clears valid; binary_out keeps the last word.
    if (wv_q && word_ready) wv_d = 1'b0;

    case (state_q)
      FETCH: begin
        // Holding an unaccepted word blocks popping, so words never overwrite.
        if (rx_data_present && !wv_q) begin
          char_d  = rx_data;
          rd_d    = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // One idle cycle lets the FIFO retire the popped entry.
        state_d = FETCH;
        if (is_digit) begin
          if (bcnt_q == BCW'(WIDTH-1)) begin
            bout_d  = {shift_q[WIDTH-2:0], char_q[0]};
            wv_d    = 1'b1;
            bcnt_d  = '0;
            shift_d = '0;
          end else begin
            shift_d = {shift_q[WIDTH-2:0], char_q[0]};
            bcnt_d  = bcnt_q + 1'b1;
          end
        end else if (is_space) begin
          // ignored
        end else if (is_eol) begin
          // Delimiter on an empty word is harmless (CRLF, blank lines).
          if (bcnt_q != '0) begin
            fe_d    = 1'b1;
            bcnt_d  = '0;
            shift_d = '0;
          end
        end else begin
          fe_d    = 1'b1;
          bcnt_d  = '0;
          shift_d = '0;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= FETCH;
      char_q  <= '0;
      shift_q <= '0;
      bcnt_q  <= '0;
      bout_q  <= '0;
      wv_q    <= 1'b0;
      fe_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      bout_q  <= bout_d;
      wv_q    <= wv_d;
      fe_q    <= fe_d;
      rd_q    <= rd_d;
    end
  end

  assign rx_read     = rd_q;
  assign binary_out  = bout_q;
  assign word_valid  = wv_q;
  assign frame_error = fe_q;
  assign bit_count   = bcnt_q;

endmodule

// File: tb/tb_receive_ascii_as_binary.sv
// Bench: two instances (whitespace allowed / disallowed) fed by FIFO models.
module tb_receive_ascii_as_binary;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- FIFO models ----------------
  logic [7:0] mem0 [512];
  logic [7:0] mem1 [512];
  int wr0 = 0, wr1 = 0;
  int rd0 = 0, rd1 = 0;
  logic flush0 = 1'b0;

  logic [7:0] rx_data0, rx_data1;
  logic present0, present1;
  logic rx_read0, rx_read1;
  logic [7:0] bout0, bout1;
  logic wv0, wv1, ready0, ready1, fe0, fe1;
  logic [3:0] bc0, bc1;

  assign rx_data0 = mem0[rd0];
  assign rx_data1 = mem1[rd1];
  assign present0 = (rd0 != wr0);
  assign present1 = (rd1 != wr1);

  always @(posedge CLK) begin
    if (flush0) rd0 <= wr0;
    else if (rx_read0) rd0 <= rd0 + 1;
    if (rx_read1) rd1 <= rd1 + 1;
  end

  receive_ascii_as_binary #(.WIDTH(8), .ALLOW_WS(1)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data0), .rx_data_present(present0),
    .rx_read(rx_read0), .binary_out(bout0), .word_valid(wv0),
    .word_ready(ready0), .frame_error(fe0), .bit_count(bc0));

  receive_ascii_as_binary #(.WIDTH(8), .ALLOW_WS(0)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data1), .rx_data_present(present1),
    .rx_read(rx_read1), .binary_out(bout1), .word_valid(wv1),
    .word_ready(ready1), .frame_error(fe1), .bit_count(bc1));

  // ---------------- monitors ----------------
  logic [7:0] got0[$], got1[$];
  int fecnt0 = 0, fecnt1 = 0, npop0 = 0, vcyc0 = 0;
  int last_pop0 = 0, rise0 = 0, proto0 = 0, proto1 = 0;
  int popq0[$];
  logic prev_rd0 = 1'b0, prev_rd1 = 1'b0, prev_wv0 = 1'b0;

  always @(negedge CLK) begin
    if (wv0 && ready0) got0.push_back(bout0);
    if (wv0) vcyc0++;
    if (fe0) fecnt0++;
    if (rx_read0) begin npop0++; last_pop0 = cyc; popq0.push_back(cyc); end
    if (rx_read0 && (!present0 || prev_rd0)) proto0++;
    if (wv0 && fe0) proto0++;
    if (wv0 && !prev_wv0) rise0 = cyc;
    prev_rd0 = rx_read0;
    prev_wv0 = wv0;
  end

  always @(negedge CLK) begin
    if (wv1 && ready1) got1.push_back(bout1);
    if (fe1) fecnt1++;
    if (rx_read1 && (!present1 || prev_rd1)) proto1++;
    if (wv1 && fe1) proto1++;
    prev_rd1 = rx_read1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input string s);
    @(posedge CLK); #1;
    for (int i = 0; i < s.len(); i++) begin
      if (sel) begin mem1[wr1] = s[i]; wr1++; end
      else     begin mem0[wr0] = s[i]; wr0++; end
    end
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      @(negedge CLK);
      n++;
      if (sel) done = (rd1 == wr1) && !rx_read1;
      else     done = (rd0 == wr0) && !rx_read0;
    end
    if (!done) chk("idle_timeout", 1, 0);
    repeat (3) @(negedge CLK);
  endtask

  typedef struct {
    string      s;
    bit         dut;
    int         nw;
    logic [7:0] w0;
    logic [7:0] w1;
    int         nfe;
    int         bc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int g, f, p, v, n;

    vecs[0]  = '{"1010 0101\r\n",      1'b0, 1, 8'hA5, 8'h00, 0, 0};
    vecs[1]  = '{"101\n",              1'b0, 0, 8'h00, 8'h00, 1, 0};
    vecs[2]  = '{"11110000",           1'b0, 1, 8'hF0, 8'h00, 0, 0};
    vecs[3]  = '{"10x01010101",        1'b0, 1, 8'h55, 8'h00, 1, 0};
    vecs[4]  = '{"\t\r\n \n\r\n",      1'b0, 0, 8'h00, 8'h00, 0, 0};
    vecs[5]  = '{"1111111100000000",   1'b0, 2, 8'hFF, 8'h00, 0, 0};
    vecs[6]  = '{"1111111\n",          1'b0, 0, 8'h00, 8'h00, 1, 0};
    vecs[7]  = '{"1010 0101",          1'b1, 0, 8'h00, 8'h00, 1, 4};
    vecs[8]  = '{"00110011",           1'b1, 1, 8'h53, 8'h00, 0, 4};
    vecs[9]  = '{"\n",                 1'b1, 0, 8'h00, 8'h00, 1, 0};
    vecs[10] = '{"01111110",           1'b1, 1, 8'h7E, 8'h00, 0, 0};

    // ---- reset with data present ----
    RST_N = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
    repeat (2) @(posedge CLK);
    push(1'b0, "10100101");
    repeat (4) @(negedge CLK);
    chk("rst_rx_read", rx_read0, 0);
    chk("rst_word_valid", wv0, 0);
    chk("rst_frame_error", fe0, 0);
    chk("rst_binary_out", bout0, 0);
    chk("rst_bit_count", bc0, 0);
    chk("rst_no_pop", rd0, 0);

    // ---- basic word, latency and pop spacing ----
    g = got0.size(); v = vcyc0; f = fecnt0; p = popq0.size();
    @(posedge CLK); #1; RST_N = 1'b1;
    wait_idle(1'b0);
    chk("basic_nwords", got0.size() - g, 1);
    if (got0.size() > g) chk("basic_word", got0[g], 8'hA5);
    chk("basic_npop", popq0.size() - p, 8);
    if (popq0.size() >= p + 8) chk("basic_pop_span", popq0[p+7] - popq0[p], 14);
    chk("basic_latency", rise0 - last_pop0, 1);
    chk("basic_valid_cycles", vcyc0 - v, 1);
    chk("basic_no_fe", fecnt0 - f, 0);

    // ---- backpressure ----
    ready0 = 1'b0;
    g = got0.size(); n = npop0;
    push(1'b0, "1111000000001111");
    begin
      int k;
      k = 0;
      while (!wv0 && k < 200) begin @(negedge CLK); k++; end
      if (!wv0) chk("bp_valid_timeout", 1, 0);
    end
    repeat (10) @(negedge CLK);
    chk("bp_held_valid", wv0, 1);
    chk("bp_held_word", bout0, 8'hF0);
    chk("bp_pops_while_held", npop0 - n, 8);
    chk("bp_fifo_left", wr0 - rd0, 8);
    @(posedge CLK); #1; ready0 = 1'b1;
    wait_idle(1'b0);
    chk("bp_nwords", got0.size() - g, 2);
    if (got0.size() >= g + 2) begin
      chk("bp_word0", got0[g], 8'hF0);
      chk("bp_word1", got0[g+1], 8'h0F);
    end
    chk("bp_retain_out", bout0, 8'h0F);
    chk("bp_valid_cleared", wv0, 0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].dut) begin g = got1.size(); f = fecnt1; end
      else             begin g = got0.size(); f = fecnt0; end
      push(vecs[i].dut, vecs[i].s);
      wait_idle(vecs[i].dut);
      if (vecs[i].dut) begin
        chk($sformatf("v%0d_nwords", i), got1.size() - g, vecs[i].nw);
        if (vecs[i].nw > 0 && got1.size() > g) chk($sformatf("v%0d_w0", i), got1[g], vecs[i].w0);
        if (vecs[i].nw > 1 && got1.size() > g + 1) chk($sformatf("v%0d_w1", i), got1[g+1], vecs[i].w1);
        chk($sformatf("v%0d_ferr", i), fecnt1 - f, vecs[i].nfe);
        chk($sformatf("v%0d_bitcnt", i), bc1, vecs[i].bc);
      end else begin
        chk($sformatf("v%0d_nwords", i), got0.size() - g, vecs[i].nw);
        if (vecs[i].nw > 0 && got0.size() > g) chk($sformatf("v%0d_w0", i), got0[g], vecs[i].w0);
        if (vecs[i].nw > 1 && got0.size() > g + 1) chk($sformatf("v%0d_w1", i), got0[g+1], vecs[i].w1);
        chk($sformatf("v%0d_ferr", i), fecnt0 - f, vecs[i].nfe);
        chk($sformatf("v%0d_bitcnt", i), bc0, vecs[i].bc);
      end
    end

    // ---- async reset mid-word ----
    push(1'b0, "11111111");
    begin
      int k;
      k = 0;
      while (bc0 != 4'd5 && k < 200) begin @(negedge CLK); k++; end
      if (bc0 != 4'd5) chk("ar_reach5_timeout", 1, 0);
    end
    #2; RST_N = 1'b0; #1;
    chk("ar_bit_count", bc0, 0);
    chk("ar_rx_read", rx_read0, 0);
    chk("ar_word_valid", wv0, 0);
    chk("ar_binary_out", bout0, 0);
    flush0 = 1'b1;
    @(posedge CLK); #1; flush0 = 1'b0;
    @(posedge CLK); #1; RST_N = 1'b1;
    g = got0.size(); f = fecnt0;
    push(1'b0, "00000001");
    wait_idle(1'b0);
    chk("ar_nwords", got0.size() - g, 1);
    if (got0.size() > g) chk("ar_word", got0[g], 8'h01);
    chk("ar_no_fe", fecnt0 - f, 0);

    chk("protocol0", proto0, 0);
    chk("protocol1", proto1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/receive_ascii_as_binary.md
Name: receive_ascii_as_binary

Overview:
- Inverse of the binary-to-ASCII sender on the UART transmit path.
- Pops characters from the uart_rx6 receive FIFO and parses a stream of ASCII '0'/'1' digits, MSB first.
- Assembles each run of WIDTH digits into a WIDTH-bit word and presents it downstream on a valid/ready handshake.
- Flags malformed input. Sits between uart_rx6 and the perceptron input/weight loading logic.

Parameters:
WIDTH, 8, number of binary digits per assembled word (legal range 2..32)
ALLOW_WS, 1, 1 = space/tab ignored and CR/LF act as word delimiters; 0 = any non-digit is an error

Ports:
CLK  input  1  system clock (same clock as uart_rx6)
RST_N  input  1  asynchronous active-low reset
rx_data  input  8  character from uart_rx6 data_out
rx_data_present  input  1  uart_rx6 buffer_data_present
rx_read  output  1  one-cycle pop pulse to uart_rx6 buffer_read
binary_out  output  WIDTH  assembled word; stable while word_valid=1
word_valid  output  1  assembled word available
word_ready  input  1  downstream accepts word
frame_error  output  1  one-cycle pulse on illegal character or truncated word
bit_count  output  clog2(WIDTH+1)  digits accumulated in the current partial word

Behaviour:
- Reset (RST_N low, asynchronous): outputs rx_read=0, binary_out=0, word_valid=0, frame_error=0, bit_count=0.
- Reset also clears the internal shift register to 0 and sets state=FETCH.
- Reset mid-operation discards the partial word and any held word. rx_read drops immediately.
- All outputs are registered.
- FSM has two states, FETCH and SETTLE.
- FETCH: if rx_data_present=1 and word_valid=0 at a posedge:
  - latch rx_data into char_reg;
  - drive rx_read=1 for exactly that next cycle;
  - go to SETTLE.
  - Otherwise stay in FETCH with rx_read=0.
- SETTLE: rx_read=0. Classify char_reg, then return to FETCH. SETTLE gives the FIFO one cycle to update rx_data_present.
  - 0x30 ('0') or 0x31 ('1'):
    - shift = {shift[WIDTH-2:0], char_reg[0]};
    - bit_count+1.
    - If bit_count reaches WIDTH: binary_out <= new shift, word_valid <= 1, bit_count <= 0, shift <= 0, all in this same edge.
  - 0x20 or 0x09, ALLOW_WS=1: ignored, no state change.
  - 0x0D or 0x0A, ALLOW_WS=1:
    - bit_count=0: ignored, so CRLF pairs and blank lines are harmless.
    - bit_count!=0: truncated word; frame_error pulse, bit_count <= 0, shift <= 0.
  - Any other byte, or whitespace/CR/LF with ALLOW_WS=0: frame_error pulse (one cycle), bit_count <= 0, shift <= 0. The character is consumed.
- Throughput: one character per 2 clocks. Latency: the posedge sampling rx_data_present of the final digit is followed by rx_read high for 1 cycle; word_valid rises at the next posedge (2 edges total).
- Output handshake:
  - word_valid stays high and binary_out stays stable until a posedge with word_ready=1.
  - word_valid clears at that edge. binary_out retains its value.
  - word_ready while word_valid=0 is ignored.
- Backpressure: while word_valid=1, FETCH does not pop. Characters remain in the uart_rx6 FIFO, with overflow handled by uart_rx6. The first pop after acceptance is on the edge following the word_valid clear.
- A word therefore never overwrites an unaccepted word. Completion and acceptance never coincide.
- rx_read is never asserted while rx_data_present=0 and is never asserted on two consecutive cycles.
- frame_error and word_valid are never set on the same edge.

Test Plan:
- Reset: hold RST_N=0 with rx_data_present=1 -> rx_read, word_valid, frame_error, binary_out, bit_count all 0; no pops.
- Basic word: WIDTH=8, FIFO holds "10100101", word_ready=1 -> 8 rx_read pulses spaced 2 clocks; word_valid for 1 cycle with binary_out=0xA5, 2 edges after the 8th sampling edge.
- Backpressure: send "1111000000001111", word_ready=0 -> binary_out=0xF0, word_valid held; no rx_read while held. Raise word_ready -> next word 0x0F, no characters lost.
- Whitespace/delimiters, ALLOW_WS=1: "1010 0101\r\n" -> single word 0xA5, no frame_error. Then "101\n" -> frame_error pulse, bit_count back to 0, no word. Then "11110000" -> 0xF0.
- Illegal character: "10x01010101" -> frame_error pulse on 'x', partial discarded; the following 8 digits yield 0x55.
- ALLOW_WS=0: "1010 0101" -> frame_error on space; no word until 8 further contiguous digits arrive.
- Async reset mid-word: assert RST_N=0 after 5 digits of "11111111", release, send "00000001" -> binary_out=0x01, with no residual bits from before reset.
